// File: rtl/pattern_gen.sv
// Video test-pattern generator: bars, checker, gradient and scrolling bars,
// with a 2-cycle colour pipeline and delayed timing signals.
module pattern_gen #(
    parameter int HSZ    = 10,
    parameter int VSZ    = 9,
    parameter int HRES   = 640,
    parameter int PIX_SZ = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [HSZ-1:0]    hcount_i,
    input  logic [VSZ-1:0]    vcount_i,
    input  logic              de_i,
    input  logic              hsync_i,
    input  logic              vsync_i,
    input  logic [1:0]        mode_i,
    output logic [PIX_SZ-1:0] o_r,
    output logic [PIX_SZ-1:0] o_g,
    output logic [PIX_SZ-1:0] o_b,
    output logic              de_o,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic [7:0]        frame_o
);

    typedef enum logic [1:0] {
        MODE_BARS   = 2'd0,
        MODE_CHECK  = 2'd1,
        MODE_GRAD   = 2'd2,
        MODE_SCROLL = 2'd3
    } mode_e;

    localparam int unsigned BAR_W  = HRES / 8;
    localparam logic [HSZ:0] HRES_W = (HSZ+1)'(HRES);

    mode_e                r_mode;
    logic [HSZ-1:0]       r_offset;
    logic                 r_vsync_prev;
    logic [3*PIX_SZ-1:0]  r_pix1;
    logic [2:0]           r_sync1;

    logic                 w_frame_evt;
    logic [HSZ:0]         w_sum;
    logic [HSZ:0]         w_sum_wrap;
    logic [HSZ:0]         w_bar_x;
    logic [2:0]           w_bar_idx;
    logic [2:0]           w_bar_rgb;
    logic                 w_active;
    logic                 w_chk;
    logic [3*PIX_SZ-1:0]  w_pix;
    logic [HSZ:0]         w_off_inc;
    logic [HSZ:0]         w_off_wrap;
    logic [HSZ-1:0]       w_off_next;
    logic                 w_unused;

    assign w_frame_evt = vsync_i & ~r_vsync_prev;
    assign w_unused    = &{1'b0, vcount_i, w_off_wrap[HSZ]};

    // Scroll position wraps once: both operands are below HRES
    assign w_sum      = {1'b0, hcount_i} + {1'b0, r_offset};
    assign w_sum_wrap = w_sum - HRES_W;
    assign w_bar_x    = (r_mode != MODE_SCROLL) ? {1'b0, hcount_i}
                      : (w_sum >= HRES_W)       ? w_sum_wrap : w_sum;

    assign w_off_inc  = {1'b0, r_offset} + (HSZ+1)'(4);
    assign w_off_wrap = w_off_inc - HRES_W;
    assign w_off_next = (w_off_inc < HRES_W) ? w_off_inc[HSZ-1:0] : w_off_wrap[HSZ-1:0];

    assign w_active = de_i && ({1'b0, hcount_i} < HRES_W);
    assign w_chk    = hcount_i[5] ^ vcount_i[5];

    always_comb begin
        w_bar_idx = '0;
        for (int unsigned i = 1; i < 8; i++) begin
            if (w_bar_x >= (HSZ+1)'(i * BAR_W))
                w_bar_idx = 3'(i);
        end
    end

    always_comb begin
        w_bar_rgb = 3'b000;
        case (w_bar_idx)
            3'd0: w_bar_rgb = 3'b111;
            3'd1: w_bar_rgb = 3'b110;
            3'd2: w_bar_rgb = 3'b011;
            3'd3: w_bar_rgb = 3'b010;
            3'd4: w_bar_rgb = 3'b101;
            3'd5: w_bar_rgb = 3'b100;
            3'd6: w_bar_rgb = 3'b001;
            default: w_bar_rgb = 3'b000;
        endcase
    end

    always_comb begin
        w_pix = '0;
        if (w_active) begin
            case (r_mode)
                MODE_CHECK: w_pix = {3*PIX_SZ{w_chk}};
                MODE_GRAD:  w_pix = {3{hcount_i[HSZ-1 -: PIX_SZ]}};
                default:    w_pix = {{PIX_SZ{w_bar_rgb[2]}}, {PIX_SZ{w_bar_rgb[1]}},
                                     {PIX_SZ{w_bar_rgb[0]}}};
            endcase
        end
    end

    // The stage-1 colour sees mode/offset before any same-cycle frame update
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vsync_prev <= 1'b1;
            r_mode       <= MODE_BARS;
            r_offset     <= '0;
            frame_o      <= '0;
            r_pix1       <= '0;
            r_sync1      <= '0;
            o_r          <= '0;
            o_g          <= '0;
            o_b          <= '0;
            de_o         <= 1'b0;
            hsync_o      <= 1'b0;
            vsync_o      <= 1'b0;
        end else begin
            r_vsync_prev <= vsync_i;
            if (w_frame_evt) begin
                frame_o  <= frame_o + 8'd1;
                r_mode   <= mode_e'(mode_i);
                r_offset <= w_off_next;
            end
            r_pix1                   <= w_pix;
            r_sync1                  <= {de_i, hsync_i, vsync_i};
            {o_r, o_g, o_b}          <= r_pix1;
            {de_o, hsync_o, vsync_o} <= r_sync1;
        end
    end

endmodule

// File: tb/tb_pattern_gen.sv
// Self-checking bench for pattern_gen: fixed vector table, directed corner
// sequences, and random stimulus against a behavioural frame/pixel model.
module tb_pattern_gen;

    localparam int HSZ = 10, VSZ = 9, HRES = 640, PIX_SZ = 4;
    localparam int FULL = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [HSZ-1:0] hcount = '0;
    logic [VSZ-1:0] vcount = '0;
    logic de = 1'b0, hs = 1'b0, vs = 1'b0;
    logic [1:0] mode = '0;
    logic [PIX_SZ-1:0] o_r, o_g, o_b;
    logic de_o, hsync_o, vsync_o;
    logic [7:0] frame_o;

    int vectors = 0;
    int errors  = 0;

    // Behavioural model state
    int m_frame = 0, m_mode = 0, m_off = 0;
    bit m_vprev = 1'b1;
    logic [14:0] m_s1 = '0, m_s2 = '0;

    pattern_gen #(.HSZ(HSZ), .VSZ(VSZ), .HRES(HRES), .PIX_SZ(PIX_SZ)) dut (
        .clk_i(clk), .rst_i(rst), .hcount_i(hcount), .vcount_i(vcount),
        .de_i(de), .hsync_i(hs), .vsync_i(vs), .mode_i(mode),
        .o_r(o_r), .o_g(o_g), .o_b(o_b),
        .de_o(de_o), .hsync_o(hsync_o), .vsync_o(vsync_o), .frame_o(frame_o)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] bar_colour(int x);
        logic [2:0] tbl [8];
        logic [2:0] c;
        tbl = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
        c = tbl[x / (HRES / 8)];
        return {{4{c[2]}}, {4{c[1]}}, {4{c[0]}}};
    endfunction

    function automatic logic [11:0] ref_pix(int md, int off, int h, int v, bit d);
        int g;
        if (!d || h >= HRES) return 12'h000;
        case (md)
            0: return bar_colour(h);
            1: return ((((h / 32) + (v / 32)) % 2) == 1) ? 12'hFFF : 12'h000;
            2: begin
                g = h / (1 << (HSZ - PIX_SZ));
                return 12'((g * 256) + (g * 16) + g);
            end
            default: return bar_colour((h + off) % HRES);
        endcase
    endfunction

    task automatic tick();
        logic [11:0] p;
        @(posedge clk);
        if (rst) begin
            m_s1 = '0; m_s2 = '0;
            m_frame = 0; m_mode = 0; m_off = 0; m_vprev = 1'b1;
        end else begin
            p = ref_pix(m_mode, m_off, int'(hcount), int'(vcount), de);
            m_s2 = m_s1;
            m_s1 = {de, hs, vs, p};
            if (vs && !m_vprev) begin
                m_frame = (m_frame + 1) % 256;
                m_mode  = int'(mode);
                m_off   = (m_off + 4) % HRES;
            end
            m_vprev = vs;
        end
        #1;
        vectors++;
        if ({de_o, hsync_o, vsync_o, o_r, o_g, o_b} !== m_s2 || frame_o !== 8'(m_frame)) begin
            errors++;
            $display("FAIL model t=%0t: got de/hs/vs/rgb=%b/%b/%b/%h frame=%0d, want %b/%b/%b/%h frame=%0d",
                     $time, de_o, hsync_o, vsync_o, {o_r, o_g, o_b}, frame_o,
                     m_s2[14], m_s2[13], m_s2[12], m_s2[11:0], m_frame);
        end
    endtask

    task automatic chk(string nm, int act, int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic frame_event(logic [1:0] md);
        de = 1'b0; vs = 1'b0; tick();
        mode = md; vs = 1'b1; tick();
        vs = 1'b0; tick();
    endtask

    typedef struct {
        string nm;
        int md, h, v;
        bit d;
        int er, eg, eb;
    } vec_t;

    vec_t tbl [16];
    int cur_mode;

    initial begin
        tbl[0]  = '{"bars h0",     0, 0,   0,  1, FULL, FULL, FULL};
        tbl[1]  = '{"bars h79",    0, 79,  0,  1, FULL, FULL, FULL};
        tbl[2]  = '{"bars h80",    0, 80,  0,  1, FULL, FULL, 0};
        tbl[3]  = '{"bars h400",   0, 400, 0,  1, FULL, 0,    0};
        tbl[4]  = '{"bars h639",   0, 639, 0,  1, 0,    0,    0};
        tbl[5]  = '{"bars h700",   0, 700, 0,  1, 0,    0,    0};
        tbl[6]  = '{"bars de0",    0, 160, 0,  0, 0,    0,    0};
        tbl[7]  = '{"bars h240",   0, 240, 5,  1, 0,    FULL, 0};
        tbl[8]  = '{"chk h32v0",   1, 32,  0,  1, FULL, FULL, FULL};
        tbl[9]  = '{"chk h32v32",  1, 32,  32, 1, 0,    0,    0};
        tbl[10] = '{"chk h0v0",    1, 0,   0,  1, 0,    0,    0};
        tbl[11] = '{"chk h700",    1, 700, 32, 1, 0,    0,    0};
        tbl[12] = '{"grad h0",     2, 0,   0,  1, 0,    0,    0};
        tbl[13] = '{"grad h64",    2, 64,  0,  1, 1,    1,    1};
        tbl[14] = '{"grad h576",   2, 576, 0,  1, 9,    9,    9};
        tbl[15] = '{"grad de0",    2, 576, 0,  0, 0,    0,    0};

        // Reset with active inputs; vsync already high at release
        rst = 1'b1; de = 1'b1; mode = 2'd3; vs = 1'b1; hcount = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset rgb", int'({o_r, o_g, o_b}), 0);
            chk("reset syncs", int'({de_o, hsync_o, vsync_o}), 0);
            chk("reset frame", int'(frame_o), 0);
        end
        rst = 1'b0;
        tick();
        chk("post-reset rgb", int'({o_r, o_g, o_b}), 0);
        chk("post-reset de", int'(de_o), 0);
        for (int i = 0; i < 3; i++) tick();
        chk("vsync held no F", int'(frame_o), 0);
        vs = 1'b0; tick();
        vs = 1'b1; tick();
        chk("first F frame", int'(frame_o), 1);
        vs = 1'b0; tick();
        cur_mode = 3;

        foreach (tbl[i]) begin
            if (tbl[i].md != cur_mode) begin
                frame_event(2'(tbl[i].md));
                cur_mode = tbl[i].md;
            end
            hcount = HSZ'(tbl[i].h); vcount = VSZ'(tbl[i].v); de = tbl[i].d;
            tick(); tick();
            chk({tbl[i].nm, " r"}, int'(o_r), tbl[i].er);
            chk({tbl[i].nm, " g"}, int'(o_g), tbl[i].eg);
            chk({tbl[i].nm, " b"}, int'(o_b), tbl[i].eb);
        end

        // Single-cycle pulses on the timing inputs emerge two cycles later only
        mode = 2'd0; de = 1'b0; hs = 1'b0; vs = 1'b0; hcount = '0;
        tick(); tick();
        de = 1'b1; hs = 1'b1; vs = 1'b1;
        tick();
        chk("pulse +1", int'({de_o, hsync_o, vsync_o}), 0);
        de = 1'b0; hs = 1'b0; vs = 1'b0;
        tick();
        chk("pulse +2", int'({de_o, hsync_o, vsync_o}), 7);
        tick();
        chk("pulse +3", int'({de_o, hsync_o, vsync_o}), 0);

        // Mode change mid-frame is ignored until the next frame start
        mode = 2'd1; hcount = 10'd100; vcount = '0; de = 1'b1;
        tick(); tick();
        chk("mode latch hold", int'({o_r, o_g, o_b}), 12'hFF0);
        frame_event(2'd1);
        hcount = 10'd100; vcount = '0; de = 1'b1;
        tick(); tick();
        chk("mode latch new", int'({o_r, o_g, o_b}), 12'hFFF);

        // Random traffic, including resets and frame starts over active pixels
        for (int i = 0; i < 600; i++) begin
            rst    = ($urandom_range(0, 59) == 0);
            hcount = HSZ'($urandom_range(0, (1 << HSZ) - 1));
            vcount = VSZ'($urandom);
            de     = 1'($urandom);
            hs     = 1'($urandom);
            if ($urandom_range(0, 5) == 0) vs = ~vs;
            mode   = 2'($urandom);
            tick();
        end

        // Scroll wrap and frame counter wrap from a clean reset
        rst = 1'b1; vs = 1'b0; tick();
        rst = 1'b0; mode = 2'd3;
        for (int k = 1; k <= 256; k++) begin
            vs = 1'b0; de = 1'($urandom);
            hcount = HSZ'($urandom_range(0, HRES - 1));
            tick();
            vs = 1'b1; de = 1'b1;
            hcount = HSZ'($urandom_range(0, HRES - 1));
            tick();
            if (k == 160 || k == 161) begin
                vs = 1'b0; hcount = 10'd76; de = 1'b1;
                tick(); tick();
                chk(k == 160 ? "scroll off0 h76" : "scroll off4 h76",
                    int'({o_r, o_g, o_b}), k == 160 ? 12'hFFF : 12'hFF0);
                if (k == 161) chk("frame 161", int'(frame_o), 161);
            end
        end
        chk("frame wrap 256", int'(frame_o), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pattern_gen.md
PATTERN_GEN -- requirements
Module: pattern_gen

Interface
REQ-001 Parameter HSZ, default 10, horizontal counter width.
REQ-002 Parameter VSZ, default 9, vertical counter width.
REQ-003 Parameter HRES, default 640, active pixels per line; must be a multiple of 8.
REQ-004 Parameter PIX_SZ, default 4, bits per colour channel.
REQ-005 Port clk_i, input, 1, pixel clock; the only clock.
REQ-006 Port rst_i, input, 1, reset, synchronous and active-high.
REQ-007 Port hcount_i, input, HSZ, current column from the timing generator.
REQ-008 Port vcount_i, input, VSZ, current row from the timing generator.
REQ-009 Port de_i, input, 1, data enable (active area).
REQ-010 Port hsync_i / vsync_i, input, 1 each, syncs from the timing generator; polarity is passed through unchanged.
REQ-011 Port mode_i, input, 2, pattern select.
REQ-012 Port o_r / o_g / o_b, output, PIX_SZ each, pixel colour.
REQ-013 Port de_o / hsync_o / vsync_o, output, 1 each, delayed copies of de_i / hsync_i / vsync_i.
REQ-014 Port frame_o, output, 8, frame counter.

Function
REQ-015 Latency is exactly 2 clk_i cycles from every input to every output.
- de_o, hsync_o and vsync_o at cycle n+2 equal de_i, hsync_i and vsync_i at cycle n.
- Colour at cycle n+2 is computed from hcount_i, vcount_i and de_i at cycle n.
REQ-016 Frame-start event F: vsync_i=1 at cycle n while the registered vsync_prev=0.
REQ-017 On F, frame_o increments by 1; the new value is visible at cycle n+1; 255 wraps to 0.
REQ-018 On F, the mode register loads mode_i. mode_i changes between F events have no effect.
REQ-019 On F, the scroll offset register (width HSZ) updates: offset <= offset+4 if offset+4 < HRES, else offset+4-HRES. It always stays in range 0..HRES-1.
REQ-020 If de_i=0, or hcount_i >= HRES, the colour output is all-zero, in every mode.
REQ-021 Bar colours: FULL = all-ones on PIX_SZ bits.
- Bar index b = x/(HRES/8), computed by a comparison chain; no divider.
- b=0..7 maps to {R,G,B} as: white {F,F,F}, yellow {F,F,0}, cyan {0,F,F}, green {0,F,0}, magenta {F,0,F}, red {F,0,0}, blue {0,0,F}, black {0,0,0}.
REQ-022 Mode 0 (bars): x = hcount_i.
REQ-023 Mode 1 (checker): white when hcount_i[5] XOR vcount_i[5] = 1, else black.
REQ-024 Mode 2 (gradient): o_r = o_g = o_b = hcount_i[HSZ-1 -: PIX_SZ].
REQ-025 Mode 3 (scroll): bar pattern with x = hcount_i + offset.
- If the sum is >= HRES, subtract HRES.
- Compute the sum at width HSZ+1 so it cannot overflow.
REQ-026 If F and the active pixels of the same cycle coincide, the pixel uses the mode and offset values held before the update.

Reset
REQ-027 While rst_i=1 at a rising edge of clk_i, the following registers clear to 0: o_r, o_g, o_b, de_o, hsync_o, vsync_o, frame_o, mode register, offset, and all pipeline stages.
REQ-028 While rst_i=1, vsync_prev is set to 1, so vsync_i already high at reset release does not generate F.
REQ-029 Reset asserted mid-frame takes effect at the next edge; outputs stay zero for 2 cycles after release, until the pipeline refills.

Verification
REQ-030 Reset: hold rst_i=1 with de_i=1 and mode_i=3 for 3 cycles, then release with vsync_i=1.
- Required: all outputs 0 during reset and for 2 cycles after release; frame_o stays 0 until vsync_i goes 0 then 1.
REQ-031 Mode 0 sweep: F with mode_i=0, then de_i=1 and hcount_i stepped 0..639.
- Required, 2 cycles later: hcount 0 -> {F,F,F}; 79 -> {F,F,F}; 80 -> {F,F,0}; 400 -> {F,0,0}; 639 -> {0,0,0}.
- Required: hcount 700 with de_i=1 -> {0,0,0}.
REQ-032 Latency and sync: a single-cycle pulse on each of hsync_i, vsync_i and de_i at cycle 10.
- Required: each pulse appears on its output at cycle 12 only.
REQ-033 Mode latch: set mode_i=1 mid-frame; no change to output.
- After the next F: hcount=32, vcount=0 -> white; hcount=32, vcount=32 -> black; hcount=0, vcount=0 -> black.
REQ-034 Scroll wrap: mode 3, apply 160 F events.
- Required: offset sequence 4, 8, ..., 636, 0 (0 after 160 events).
- Required: after 161 F events (offset 4), hcount=76 -> yellow.
- Required: frame_o=161 after 161 events; wraps to 0 after 256 events.
REQ-035 Mode 2 gradient: hcount=0 -> 0; hcount=64 -> 1; hcount=576 -> 9 on all three channels.
